// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter feeding one UART transmitter.
// Ports: clk, rst (async, active-high); req0/req1 valid/data/ready
//   (echo path / counter report path); tx_start, tx_din, tx_busy to the
//   transmitter; grant (one-hot frame owner); timeout_err (ack timeout).
module tx_arbiter #(
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_din,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [7:0] ACK_LIM  = 8'(ACK_TIMEOUT);
  localparam logic [7:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] din_q, din_d;
  logic [1:0] grant_q, grant_d;
  // set when requester 1 wins a tie next
  logic       prio1_q, prio1_d;
  logic       pick1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      din_q   <= 8'd0;
      grant_q <= 2'b00;
      prio1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      grant_q <= grant_d;
      prio1_q <= prio1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    grant_d     = grant_q;
    prio1_d     = prio1_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    pick1 = req1_valid && (!req0_valid || prio1_q);

    unique case (state_q)
      IDLE: begin
        // ready is combinational; hold it off while reset is applied
        if ((req0_valid || req1_valid) && !rst) begin
          req1_ready = pick1;
          req0_ready = !pick1;
          din_d      = pick1 ? req1_data : req0_data;
          grant_d    = pick1 ? 2'b10 : 2'b01;
          prio1_d    = !pick1;
          state_d    = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == ACK_LIM) begin
          timeout_err = 1'b1;
          state_d     = HAS_GAP ? GAP : IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = HAS_GAP ? GAP : IDLE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE && state_q != IDLE) begin
      grant_d = 2'b00;
    end

    // restart on every state change, saturate otherwise
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign tx_din = din_q;
  assign grant  = grant_q;

endmodule
